// File: rtl/tdc_coarse_mc.sv
// Multi-channel coarse TDC: a free-running coarse counter started by hit, with per-channel capture registers.
// Define TDC_COARSE_EPOCH_EN to wrap the counter and count epochs; otherwise the counter saturates and flags ovf.
module tdc_coarse_mc #(
  parameter int CNT_W   = 8,
  parameter int NCH     = 4,
  parameter int EPOCH_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hit,
  input  logic                   clear,
  input  logic [NCH-1:0]         store,
  input  logic [NCH-1:0]         sel,
  input  logic [NCH-1:0]         rd_ack,
  output logic [NCH*CNT_W-1:0]   count,
  output logic [NCH*EPOCH_W-1:0] epoch,
  output logic [NCH-1:0]         valid,
  output logic [NCH-1:0]         lost,
  output logic                   ovf,
  output logic                   running
);

  typedef enum logic [1:0] {IDLE, RUN, SAT} state_t;

  localparam logic [CNT_W-1:0] CTR_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] ctr, ctr_d;
  logic             at_max;

  assign at_max  = (ctr == CTR_MAX);
  assign running = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // clear is applied last so it overrides hit and saturation
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hit) state_nxt = RUN;
      RUN: begin
`ifndef TDC_COARSE_EPOCH_EN
        if (at_max) state_nxt = SAT;
`endif
      end
      default: state_nxt = state;
    endcase
    if (clear) state_nxt = IDLE;
  end

  // Zeroing on the way into IDLE keeps the first RUN cycle at ctr = ctr_d = 0
  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) begin
      ctr   <= '0;
      ctr_d <= '0;
    end else if (state == RUN) begin
      ctr_d <= ctr;
`ifdef TDC_COARSE_EPOCH_EN
      ctr   <= ctr + 1'b1;
`else
      if (!at_max) ctr <= ctr + 1'b1;
`endif
    end
  end

`ifdef TDC_COARSE_EPOCH_EN
  logic [EPOCH_W-1:0] ep, ep_d;

  // ep_d tracks ep one cycle late so it stays paired with ctr_d across a wrap
  always_ff @(posedge clk) begin
    if (rst || state_nxt == IDLE) begin
      ep   <= '0;
      ep_d <= '0;
    end else if (state == RUN) begin
      ep_d <= ep;
      if (at_max) ep <= ep + 1'b1;
    end
  end

  assign ovf = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (rst)                        ovf <= 1'b0;
    else if (state == RUN && at_max) ovf <= 1'b1;
  end

  assign epoch = '0;
`endif

  // A store is dropped only when the channel still holds an unacknowledged result
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      valid <= '0;
      lost  <= '0;
`ifdef TDC_COARSE_EPOCH_EN
      epoch <= '0;
`endif
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (store[i] && state != IDLE) begin
          if (!valid[i] || rd_ack[i]) begin
            count[i*CNT_W +: CNT_W] <= (state == SAT) ? CTR_MAX : (sel[i] ? ctr_d : ctr);
`ifdef TDC_COARSE_EPOCH_EN
            epoch[i*EPOCH_W +: EPOCH_W] <= sel[i] ? ep_d : ep;
`endif
            valid[i] <= 1'b1;
          end else begin
            lost[i] <= 1'b1;
          end
        end else if (rd_ack[i]) begin
          valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_coarse_mc.sv
// Self-checking bench for tdc_coarse_mc against a cycle-index reference model.
// Honours TDC_COARSE_EPOCH_EN the same way as the design.
`timescale 1ns/100ps
module tb_tdc_coarse_mc;

  localparam int CNT_W   = 8;
  localparam int NCH     = 4;
  localparam int EPOCH_W = 8;
  localparam int MAXV    = (1 << CNT_W) - 1;
`ifdef TDC_COARSE_EPOCH_EN
  localparam bit EPOCH_MODE = 1'b1;
`else
  localparam bit EPOCH_MODE = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, hit, clear;
  logic [NCH-1:0]         store, sel, rd_ack;
  logic [NCH*CNT_W-1:0]   count;
  logic [NCH*EPOCH_W-1:0] epoch;
  logic [NCH-1:0]         valid, lost;
  logic                   ovf, running;

  int tests    = 0;
  int failures = 0;

  tdc_coarse_mc #(.CNT_W(CNT_W), .NCH(NCH), .EPOCH_W(EPOCH_W)) dut (
    .clk(clk), .rst(rst), .hit(hit), .clear(clear),
    .store(store), .sel(sel), .rd_ack(rd_ack),
    .count(count), .epoch(epoch), .valid(valid), .lost(lost),
    .ovf(ovf), .running(running)
  );

  always #2.5 clk = ~clk;

  // Model: m_n is the index of the current RUN cycle since hit
  bit           m_active;
  int           m_n;
  int           m_count [NCH];
  int           m_epoch [NCH];
  bit [NCH-1:0] m_valid, m_lost;
  bit           m_ovf;

  function automatic bit m_sat();
    return !EPOCH_MODE && m_active && (m_n > MAXV);
  endfunction

  function automatic int snap_ctr(bit s);
    if (m_sat()) return MAXV;
    if (s) return (m_n == 0) ? 0 : (m_n - 1) % (MAXV + 1);
    return m_n % (MAXV + 1);
  endfunction

  function automatic int snap_ep(bit s);
    int k;
    if (!EPOCH_MODE) return 0;
    k = s ? ((m_n == 0) ? 0 : m_n - 1) : m_n;
    return (k / (MAXV + 1)) % (1 << EPOCH_W);
  endfunction

  task automatic checkVal(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    for (int i = 0; i < NCH; i++) begin
      checkVal($sformatf("%s count%0d", tag, i), int'(count[i*CNT_W +: CNT_W]), m_count[i]);
      checkVal($sformatf("%s epoch%0d", tag, i), int'(epoch[i*EPOCH_W +: EPOCH_W]), m_epoch[i]);
      checkVal($sformatf("%s valid%0d", tag, i), int'(valid[i]), int'(m_valid[i]));
      checkVal($sformatf("%s lost%0d", tag, i), int'(lost[i]), int'(m_lost[i]));
    end
    checkVal({tag, " ovf"}, int'(ovf), int'(m_ovf));
    checkVal({tag, " running"}, int'(running), int'(m_active && !m_sat()));
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic c,
                               input logic [NCH-1:0] st, input logic [NCH-1:0] se,
                               input logic [NCH-1:0] ack);
    rst = r; hit = h; clear = c; store = st; sel = se; rd_ack = ack;
    @(posedge clk);
    if (r) begin
      m_active = 0; m_n = 0; m_valid = '0; m_lost = '0; m_ovf = 0;
      for (int i = 0; i < NCH; i++) begin m_count[i] = 0; m_epoch[i] = 0; end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (st[i] && m_active) begin
          if (!m_valid[i] || ack[i]) begin
            m_count[i] = snap_ctr(se[i]);
            m_epoch[i] = snap_ep(se[i]);
            m_valid[i] = 1'b1;
          end else m_lost[i] = 1'b1;
        end else if (ack[i]) m_valid[i] = 1'b0;
      end
      if (!EPOCH_MODE && m_active && m_n >= MAXV) m_ovf = 1'b1;
      if (c)             begin m_active = 0; m_n = 0; end
      else if (m_active) m_n++;
      else if (h)        begin m_active = 1; m_n = 0; end
    end
    #1;
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(0, 0, 0, '0, '0, '0);
      checkOutput(tag);
    end
  endtask

  initial begin
    int expv;
    applyStimulus(1, 0, 0, '0, '0, '0);
    applyStimulus(1, 1, 1, '1, '1, '1);
    checkOutput("reset");
    checkVal("reset running", int'(running), 0);

    // ctr=10 capture with sel=0
    applyStimulus(0, 1, 0, '0, '0, '0);
    idle(10, "run0");
    applyStimulus(0, 0, 0, 4'b0001, 4'b0000, '0);
    checkOutput("cap sel0");
    checkVal("cap sel0 count0=10", int'(count[CNT_W-1:0]), 10);
    checkVal("cap sel0 valid0", int'(valid[0]), 1);
    applyStimulus(0, 0, 0, '0, '0, 4'b0001);
    checkOutput("ack0");

    // same capture with sel=1
    applyStimulus(0, 0, 1, '0, '0, '0);
    checkOutput("clear");
    applyStimulus(0, 1, 0, '0, '0, '0);
    idle(10, "run1");
    applyStimulus(0, 0, 0, 4'b0001, 4'b0001, '0);
    checkOutput("cap sel1");
    checkVal("cap sel1 count0=9", int'(count[CNT_W-1:0]), 9);

    // overrun on channel 1, then simultaneous store and ack
    applyStimulus(0, 0, 0, 4'b0010, '0, '0);
    checkOutput("ch1 first");
    expv = m_count[1];
    idle(3, "ch1 wait");
    applyStimulus(0, 0, 0, 4'b0010, '0, '0);
    checkOutput("ch1 drop");
    checkVal("ch1 drop count held", int'(count[CNT_W +: CNT_W]), expv);
    checkVal("ch1 drop lost", int'(lost[1]), 1);
    idle(2, "ch1 wait2");
    expv = snap_ctr(1'b0);
    applyStimulus(0, 0, 0, 4'b0010, '0, 4'b0010);
    checkOutput("ch1 store+ack");
    checkVal("ch1 store+ack count", int'(count[CNT_W +: CNT_W]), expv);
    checkVal("ch1 store+ack valid", int'(valid[1]), 1);

    // randomized traffic with occasional hit/clear
    for (int k = 0; k < 300; k++) begin
      applyStimulus(0, ($urandom_range(7) == 0), ($urandom_range(31) == 0),
                    NCH'($urandom & $urandom), NCH'($urandom), NCH'($urandom & $urandom));
      checkOutput("random");
    end

    // reset mid-RUN with all channels holding results
    applyStimulus(0, 0, 1, '0, '0, '1);
    applyStimulus(0, 1, 0, '0, '0, '0);
    idle(5, "pre-rst");
    applyStimulus(0, 0, 0, '1, 4'b0101, '0);
    checkOutput("all valid");
    checkVal("all valid mask", int'(valid), 15);
    applyStimulus(1, 1, 0, '1, '1, '0);
    checkOutput("mid-run rst");
    checkVal("mid-run rst valid", int'(valid), 0);
    checkVal("mid-run rst count", int'(count), 0);

    // hit and clear together stay in IDLE; stores in IDLE are ignored
    applyStimulus(0, 1, 1, '0, '0, '0);
    checkOutput("hit+clear");
    checkVal("hit+clear running", int'(running), 0);
    applyStimulus(0, 0, 0, '1, '0, '0);
    checkOutput("idle store");
    checkVal("idle store valid", int'(valid), 0);

    // long run
    applyStimulus(0, 1, 0, '0, '0, '0);
`ifdef TDC_COARSE_EPOCH_EN
    while (m_n < 256) begin applyStimulus(0, 0, 0, '0, '0, '0); checkOutput("long"); end
    applyStimulus(0, 0, 0, 4'b0001, 4'b0001, '0);
    checkOutput("wrap sel1");
    checkVal("wrap sel1 count0=255", int'(count[CNT_W-1:0]), 255);
    checkVal("wrap sel1 epoch0=0", int'(epoch[EPOCH_W-1:0]), 0);
    while (m_n < 600) begin applyStimulus(0, 0, 0, '0, '0, '0); checkOutput("long"); end
    applyStimulus(0, 0, 0, 4'b0010, 4'b0000, '0);
    checkOutput("600 cap");
    checkVal("600 count1=88", int'(count[CNT_W +: CNT_W]), 88);
    checkVal("600 epoch1=2", int'(epoch[EPOCH_W +: EPOCH_W]), 2);
    checkVal("600 ovf", int'(ovf), 0);
`else
    while (m_n < 300) begin applyStimulus(0, 0, 0, '0, '0, '0); checkOutput("long"); end
    checkVal("sat ovf", int'(ovf), 1);
    checkVal("sat running", int'(running), 0);
    applyStimulus(0, 0, 0, 4'b0100, 4'b0100, '0);
    checkOutput("sat cap");
    checkVal("sat cap count2=255", int'(count[2*CNT_W +: CNT_W]), 255);
    checkVal("sat epoch2", int'(epoch[2*EPOCH_W +: EPOCH_W]), 0);
`endif
    applyStimulus(0, 0, 1, '0, '0, '0);
    checkOutput("final clear");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/tdc_coarse_mc.md
TDC_COARSE_MC -- requirements
Module: tdc_coarse_mc

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the coarse counter width in bits (legal range 4..16).
REQ-002 Parameter NCH, default 4, SHALL set the number of capture channels (legal range 1..16).
REQ-003 Parameter EPOCH_W, default 8, SHALL set the epoch counter width in bits (legal range 1..16).
REQ-004 Port clk, input, 1 bit: the single clock, 200 MHz, rising edge only.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port hit, input, 1 bit: start pulse; IDLE->RUN.
REQ-007 Port clear, input, 1 bit: return to IDLE from any state.
REQ-008 Port store, input, NCH bits: per-channel capture request, one bit per channel.
REQ-009 Port sel, input, NCH bits: per-channel fine phase bit, sampled with store.
REQ-010 Port rd_ack, input, NCH bits: per-channel consume of held result.
REQ-011 Port count, output, NCH*CNT_W bits: channel i result at bits [i*CNT_W +: CNT_W].
REQ-012 Port epoch, output, NCH*EPOCH_W bits: channel i epoch at bits [i*EPOCH_W +: EPOCH_W].
REQ-013 Port valid, output, NCH bits: channel i holds an unconsumed result.
REQ-014 Port lost, output, NCH bits: sticky, channel i dropped a capture.
REQ-015 Port ovf, output, 1 bit: sticky, counter saturated (only without macro).
REQ-016 Port running, output, 1 bit: high in state RUN.

Function
REQ-017 FSM states SHALL be IDLE, RUN and SAT; IDLE->RUN on hit; RUN->SAT on saturation (without macro only); any state->IDLE on clear; clear SHALL win over hit in the same cycle.
REQ-018 In IDLE, ctr and ctr_d SHALL hold 0 and store SHALL be ignored.
REQ-019 In RUN, ctr SHALL increment by 1 each cycle and ctr_d SHALL register the previous ctr value (ctr_d = ctr-1 modulo 2^CNT_W, after the first RUN cycle).
REQ-020 The first RUN cycle after hit SHALL have ctr=0 and ctr_d=0.
REQ-021 Store capture: store[i]=1 in RUN or SAT SHALL, at the next edge, load count_i with ctr if sel[i]=0 or ctr_d if sel[i]=1, and set valid[i] (latency 1 cycle).
REQ-022 Captured epoch_i SHALL be the epoch paired with the selected counter value, so a sel=1 capture at ctr=0 SHALL return the pre-wrap epoch.
REQ-023 valid[i] SHALL clear on rd_ack[i]; rd_ack[i] with valid[i]=0 SHALL have no effect.
REQ-024 store[i] while valid[i]=1 and rd_ack[i]=0 SHALL be dropped: count_i is held and lost[i] is set.
REQ-025 store[i] and rd_ack[i] in the same cycle SHALL capture the new value with valid[i] held at 1, and SHALL NOT set lost[i].
REQ-026 Channels SHALL be independent: simultaneous stores on all channels SHALL all capture the same ctr/ctr_d snapshot.
REQ-027 clear SHALL NOT alter count, epoch, valid or lost.
REQ-028 lost and ovf SHALL clear only on rst.
REQ-029 running SHALL be 1 exactly when the state is RUN.

Reset
REQ-030 On rst at a rising clk edge, the block SHALL enter IDLE and clear ctr, ctr_d, the epoch counter, count, epoch, valid, lost and ovf to 0.
REQ-031 rst SHALL take priority over hit, clear, store and rd_ack, including mid-RUN.

Configuration
REQ-032 With macro TDC_COARSE_EPOCH_EN defined, ctr SHALL wrap from all-ones to 0, the epoch counter SHALL increment on each wrap and itself wrap modulo 2^EPOCH_W, SAT SHALL be unreachable and ovf SHALL be held at 0.
REQ-033 Without TDC_COARSE_EPOCH_EN, ctr SHALL stop at all-ones, the FSM SHALL enter SAT and set ovf, stores in SAT SHALL capture all-ones, and the epoch outputs SHALL be held at 0.

Verification
REQ-034 The bench SHALL cover: CNT_W=8, NCH=4; hit, then store[0]=1 with sel=0 in the 11th RUN cycle (ctr=10) -> next cycle count_0=10, valid[0]=1.
REQ-035 The bench SHALL cover: the same capture with sel[0]=1 -> count_0=9; with the macro, a sel=1 capture at ctr=0 after the first wrap -> count_0=255, epoch_0=0.
REQ-036 The bench SHALL cover: a store on channel 1 with no rd_ack, then a second store -> count_1 unchanged and lost[1]=1; store and rd_ack together -> new value captured, valid stays 1, lost unchanged.
REQ-037 The bench SHALL cover: without the macro, 300 cycles of RUN -> ovf=1 after 255 counts, running=0, and a store captures 255.
REQ-038 The bench SHALL cover: with the macro, 600 cycles of RUN -> epoch=2, and a store at 600 cycles after start captures ctr=88.
REQ-039 The bench SHALL cover: rst asserted mid-RUN with valid=4'b1111 -> next cycle all outputs 0 and state IDLE; hit and clear in the same cycle -> block remains in IDLE.
